// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// hazard_ctrl : load-use stall / taken-branch flush controller for the 5-stage
//               core, with saturating stall and flush event counters.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_CYCLES   = 2,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken_ex,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] c_STALL_RELOAD = 2'(LOAD_USE_STALL - 1);
    localparam logic [1:0] c_FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic w_hazard;
    logic w_pcwrite;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;

    assign w_hazard = ex_MemRead & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (ex_rd == id_rs1)) |
                       (id_use_rs2 & (ex_rd == id_rs2)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pcwrite     = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;

        // A taken branch wins in every state: redirect and start a flush run.
        if (branch_taken_ex) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = S_FLUSH;
                w_cnt_nxt   = c_FLUSH_RELOAD;
            end else begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 2'd0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_hazard) begin
                        w_pcwrite     = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            w_state_nxt = S_STALL;
                            w_cnt_nxt   = c_STALL_RELOAD;
                        end
                    end
                end
                S_STALL: begin
                    w_pcwrite     = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_cnt_nxt     = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_FLUSH: begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    w_cnt_nxt     = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Reset must quiesce the pipeline immediately, independent of the clock.
    assign PCWrite      = rst ? 1'b0 : w_pcwrite;
    assign IF_ID_Write  = rst ? 1'b0 : w_ifid_write;
    assign IF_ID_Flush  = rst ? 1'b1 : w_ifid_flush;
    assign ID_EX_Bubble = rst ? 1'b1 : w_idex_bubble;
    assign busy         = ~rst & (r_state != S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!w_pcwrite && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + c_CNT_ONE;
            end
            if (w_ifid_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + c_CNT_ONE;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_hazard_ctrl : directed self-checking bench; two instances share stimulus
//                  (A: 1-cycle stall, 8-bit counters; B: 3-cycle stall).
// Revision       : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_MemRead;
    logic [4:0] ex_rd;
    logic       branch_taken_ex;

    logic        a_pcw, a_ifw, a_fl, a_bub, a_busy;
    logic [7:0]  a_stall, a_flush;
    logic        b_pcw, b_ifw, b_fl, b_bub, b_busy;
    logic [31:0] b_stall, b_flush;

    int n_cmp;
    int n_err;

    hazard_ctrl #(.LOAD_USE_STALL(1), .FLUSH_CYCLES(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
        .branch_taken_ex(branch_taken_ex),
        .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_fl),
        .ID_EX_Bubble(a_bub), .busy(a_busy),
        .stall_count(a_stall), .flush_count(a_flush)
    );

    hazard_ctrl #(.LOAD_USE_STALL(3), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
        .branch_taken_ex(branch_taken_ex),
        .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_fl),
        .ID_EX_Bubble(b_bub), .busy(b_busy),
        .stall_count(b_stall), .flush_count(b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_MemRead      = 1'b0;
        ex_rd           = 5'd0;
        branch_taken_ex = 1'b0;
    endtask

    task automatic load_use_rs1();
        ex_MemRead = 1'b1;
        ex_rd      = 5'd5;
        id_rs1     = 5'd5;
        id_use_rs1 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        #2;
        chk("rst_pcw",   a_pcw, 0);
        chk("rst_ifw",   a_ifw, 0);
        chk("rst_fl",    a_fl, 1);
        chk("rst_bub",   a_bub, 1);
        chk("rst_busy",  a_busy, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_flush", b_flush, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("run_pcw",  a_pcw, 1);
        chk("run_ifw",  b_ifw, 1);
        chk("run_bub",  a_bub, 0);

        // Load-use on rs1
        tick(); load_use_rs1(); #1;
        chk("lu_a_pcw",  a_pcw, 0);
        chk("lu_a_ifw",  a_ifw, 0);
        chk("lu_a_bub",  a_bub, 1);
        chk("lu_a_fl",   a_fl, 0);
        chk("lu_a_busy", a_busy, 0);
        chk("lu_b_pcw",  b_pcw, 0);
        chk("lu_b_busy", b_busy, 0);
        tick(); idle(); #1;
        chk("lu_a_pcw2",  a_pcw, 1);
        chk("lu_a_bub2",  a_bub, 0);
        chk("lu_a_stall", a_stall, 1);
        chk("lu_b_pcw2",  b_pcw, 0);
        chk("lu_b_busy2", b_busy, 1);
        chk("lu_b_st1",   b_stall, 1);
        tick(); #1;
        chk("lu_b_pcw3",  b_pcw, 0);
        chk("lu_b_busy3", b_busy, 1);
        chk("lu_b_st2",   b_stall, 2);
        tick(); #1;
        chk("lu_b_pcw4",  b_pcw, 1);
        chk("lu_b_busy4", b_busy, 0);
        chk("lu_b_st3",   b_stall, 3);

        // Masking: rd=x0, then rs2 unused
        ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
        chk("mask_x0_pcw", a_pcw, 1);
        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; #1;
        chk("mask_rs2_pcw", a_pcw, 1);
        chk("mask_rs2_b",   b_pcw, 1);
        tick(); #1;
        chk("mask_a_stall", a_stall, 1);
        chk("mask_b_stall", b_stall, 3);
        // rs2 comparison enabled
        id_use_rs2 = 1'b1; #1;
        chk("rs2_hit_pcw", a_pcw, 0);
        tick(); idle(); #1;
        chk("rs2_a_stall", a_stall, 2);
        tick(); tick(); #1;
        chk("rs2_b_stall", b_stall, 6);
        chk("rs2_b_busy",  b_busy, 0);

        // Branch flush, then a second branch inside FLUSH
        branch_taken_ex = 1'b1; #1;
        chk("br_fl",   a_fl, 1);
        chk("br_bub",  a_bub, 1);
        chk("br_pcw",  a_pcw, 1);
        chk("br_ifw",  a_ifw, 1);
        chk("br_busy", a_busy, 0);
        tick(); branch_taken_ex = 1'b0; #1;
        chk("br2_fl",    a_fl, 1);
        chk("br2_pcw",   a_pcw, 1);
        chk("br2_busy",  a_busy, 1);
        chk("br2_flush", a_flush, 1);
        tick(); #1;
        chk("br3_fl",    a_fl, 0);
        chk("br3_busy",  a_busy, 0);
        chk("br3_flush", a_flush, 2);
        branch_taken_ex = 1'b1; #1;
        tick(); #1;
        chk("rebr_fl", a_fl, 1);
        tick(); branch_taken_ex = 1'b0; #1;
        chk("rebr2_fl",   a_fl, 1);
        chk("rebr2_busy", a_busy, 1);
        tick(); #1;
        chk("rebr3_fl",    a_fl, 0);
        chk("rebr_flush_a", a_flush, 5);
        chk("rebr_flush_b", b_flush, 5);

        // Hazard and branch together resolve as a branch
        load_use_rs1(); branch_taken_ex = 1'b1; #1;
        chk("hb_a_pcw", a_pcw, 1);
        chk("hb_a_fl",  a_fl, 1);
        chk("hb_b_pcw", b_pcw, 1);
        tick(); idle(); #1;
        chk("hb_a_stall", a_stall, 2);
        chk("hb_b_stall", b_stall, 6);
        chk("hb_flush",   a_flush, 6);
        tick(); #1;
        chk("hb_flush2",  b_flush, 7);
        chk("hb_b_busy",  b_busy, 0);

        // Branch arriving in the second STALL cycle of B
        load_use_rs1(); #1;
        chk("bs_b_pcw1", b_pcw, 0);
        tick(); idle(); #1;
        chk("bs_b_pcw2", b_pcw, 0);
        tick(); branch_taken_ex = 1'b1; #1;
        chk("bs_b_pcw3", b_pcw, 1);
        chk("bs_b_fl3",  b_fl, 1);
        chk("bs_b_st",   b_stall, 8);
        tick(); branch_taken_ex = 1'b0; #1;
        chk("bs_b_fl4",   b_fl, 1);
        chk("bs_b_busy4", b_busy, 1);
        tick(); #1;
        chk("bs_b_stall", b_stall, 8);
        chk("bs_b_flush", b_flush, 9);
        chk("bs_a_stall", a_stall, 3);
        chk("bs_b_busy",  b_busy, 0);

        // Asynchronous reset in the middle of a flush
        branch_taken_ex = 1'b1; #1;
        tick(); branch_taken_ex = 1'b0; #2;
        chk("ar_pre_busy", a_busy, 1);
        rst = 1'b1; #1;
        chk("ar_pcw",   a_pcw, 0);
        chk("ar_ifw",   b_ifw, 0);
        chk("ar_fl",    a_fl, 1);
        chk("ar_bub",   b_bub, 1);
        chk("ar_busy",  a_busy, 0);
        chk("ar_stall", b_stall, 0);
        chk("ar_flush", a_flush, 0);
        #3;
        rst = 1'b0; #1;
        chk("ar_rel_pcw",  a_pcw, 1);
        chk("ar_rel_busy", b_busy, 0);
        tick();
        chk("ar_rel_stall", a_stall, 0);
        chk("ar_rel_flush", b_flush, 0);

        // Continuous hazard: 8-bit counter saturates, 32-bit keeps counting
        load_use_rs1();
        repeat (260) tick();
        chk("sat_a_stall", a_stall, 255);
        chk("sat_b_stall", b_stall, 260);
        chk("sat_a_pcw",   a_pcw, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
